// File: rtl/wrr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_arb_pkg
//  Description : Shared types and helpers for the weighted round-robin
//                session arbiter (FSM state encoding, index width helper).
//  Revision    : 1.0  initial release
// ============================================================================
package wrr_arb_pkg;

    // Arbiter ownership state: nobody holds the resource, or one owner does.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Width of an index into n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating-priority selector. Returns the first
//                set request found when scanning upward from ptr, wrapping
//                modulo N_REQ, as one-hot, index and any-valid.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import wrr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan N_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        int k;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        k      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!valid && req[k]) begin
                valid     = 1'b1;
                onehot[k] = 1'b1;
                idx       = IDX_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wrr_session_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_session_arbiter
//  Description : Weighted round-robin arbiter granting exclusive multi-cycle
//                sessions to one of N_REQ requesters. An owner keeps the
//                grant for up to max(weight,1) consecutive sessions while it
//                keeps requesting, then priority rotates past it.
//                Optional feature macro: WRR_ARB_TIMEOUT_EN -- when defined,
//                a session counter forces a release after TIMEOUT_CYCLES.
//  Revision    : 1.0  initial release
// ============================================================================
module wrr_session_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int WEIGHT_W       = 3,
    parameter int TIMEOUT_CYCLES = 64
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WEIGHT_W-1:0] weights,
    input  logic                      session_is_finished,
    output logic [N_REQ-1:0]          grant,
    output logic                      grant_valid,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      timeout
);

    localparam int C_IDX_W = idx_width(N_REQ);

    // Elaboration-time guard on the parameter ranges this block supports.
    generate
        if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
            $error("wrr_session_arbiter: N_REQ must be in 2..16");
        end
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("wrr_session_arbiter: TIMEOUT_CYCLES must be >= 2");
        end
    endgenerate

    arb_state_t          r_state;
    logic [C_IDX_W-1:0]  r_ptr;
    logic [WEIGHT_W-1:0] r_credit;

    logic [WEIGHT_W-1:0] w_credit_dec;
    logic                w_finish;
    logic                w_keep;
    logic                w_force;
    logic                w_rotate;
    logic [C_IDX_W-1:0]  w_next_ptr;
    logic [C_IDX_W-1:0]  w_arb_ptr;
    logic [N_REQ-1:0]    w_others;
    logic [N_REQ-1:0]    w_elig;
    logic [N_REQ-1:0]    w_pick_oh;
    logic [C_IDX_W-1:0]  w_pick_idx;
    logic                w_pick_valid;
    logic [WEIGHT_W-1:0] w_pick_weight;
    logic [WEIGHT_W-1:0] w_load_credit;

    // A finish only means something while a session is open.
    assign w_finish     = (r_state == BUSY) && session_is_finished;
    assign w_credit_dec = r_credit - WEIGHT_W'(1);

    // Owner keeps the grant if it still has credit and still wants it.
    assign w_keep   = w_finish && (w_credit_dec != '0) && req[grant_id];
    assign w_rotate = (w_finish && !w_keep) || w_force;

    // Priority moves one past the current owner, wrapping at N_REQ-1.
    assign w_next_ptr = (grant_id == C_IDX_W'(N_REQ - 1)) ? '0
                                                          : grant_id + C_IDX_W'(1);
    assign w_arb_ptr  = (r_state == BUSY) ? w_next_ptr : r_ptr;

    // The outgoing owner competes again only when nobody else is asking.
    // In IDLE the grant is zero, so this reduces to plain req.
    assign w_others = req & ~grant;
    assign w_elig   = (w_others != '0) ? w_others : req;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (C_IDX_W)
    ) u_pick (
        .req    (w_elig),
        .ptr    (w_arb_ptr),
        .onehot (w_pick_oh),
        .idx    (w_pick_idx),
        .valid  (w_pick_valid)
    );

    // Weight of the candidate winner; zero is promoted to one.
    assign w_pick_weight = weights[int'(w_pick_idx)*WEIGHT_W +: WEIGHT_W];
    assign w_load_credit = (w_pick_weight == '0) ? WEIGHT_W'(1) : w_pick_weight;

    // Ownership FSM: grant load, credit-based re-grant and rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_credit    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state     <= BUSY;
                        grant       <= w_pick_oh;
                        grant_valid <= 1'b1;
                        grant_id    <= w_pick_idx;
                        r_credit    <= w_load_credit;
                    end
                end
                BUSY: begin
                    if (w_keep) begin
                        r_credit <= w_credit_dec;
                    end else if (w_rotate) begin
                        r_ptr <= w_next_ptr;
                        if (w_pick_valid) begin
                            grant       <= w_pick_oh;
                            grant_valid <= 1'b1;
                            grant_id    <= w_pick_idx;
                            r_credit    <= w_load_credit;
                        end else begin
                            r_state     <= IDLE;
                            grant       <= '0;
                            grant_valid <= 1'b0;
                            grant_id    <= '0;
                            r_credit    <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef WRR_ARB_TIMEOUT_EN
    localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [C_CNT_W-1:0] r_sess_cnt;

    // Force a release once the session has lasted TIMEOUT_CYCLES without a
    // finish; a finish on the same edge takes precedence.
    assign w_force = (r_state == BUSY) && !session_is_finished &&
                     (r_sess_cnt == C_CNT_W'(TIMEOUT_CYCLES - 1));

    // Session length counter and the one-cycle forced-release pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sess_cnt <= '0;
            timeout    <= 1'b0;
        end else begin
            timeout <= w_force;
            if ((r_state != BUSY) || w_keep || w_rotate) begin
                r_sess_cnt <= '0;
            end else begin
                r_sess_cnt <= r_sess_cnt + C_CNT_W'(1);
            end
        end
    end
`else
    // Sessions are unbounded: no forced release ever happens.
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire
